// File: rtl/axis_stream_sink_pkg.sv
//==============================================================================
// Module  : axis_stream_sink_pkg
// Brief   : Shared types and helpers for the AXI-Stream sink (checker state,
//           pointer sizing, saturating counter increment).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package axis_stream_sink_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } chk_state_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Counter is carried in a 64-bit container; width selects where it saturates.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] ones;
        ones = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value == ones) ? value : value + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_stream_sink_if.sv
//==============================================================================
// Module  : axis_stream_sink_if
// Brief   : Stream, pop and status bundle for axis_stream_sink.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface axis_stream_sink_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] S_AXIS_TDATA;
    logic                  S_AXIS_TVALID;
    logic                  S_AXIS_TLAST;
    logic                  S_AXIS_TREADY;
    logic                  rd_en;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic [LVL_W-1:0]      level;
    logic [CNT_WIDTH-1:0]  pkt_cnt;
    logic [CNT_WIDTH-1:0]  err_cnt;
    logic                  seq_err;
    logic                  clr;

    modport master (
        output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, rd_en, clr,
        input  S_AXIS_TREADY, rd_valid, rd_data, rd_last, level, pkt_cnt, err_cnt, seq_err
    );

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, rd_en, clr,
        output S_AXIS_TREADY, rd_valid, rd_data, rd_last, level, pkt_cnt, err_cnt, seq_err
    );

endinterface

`default_nettype wire

// File: rtl/axis_sink_fifo.sv
//==============================================================================
// Module  : axis_sink_fifo
// Brief   : First-word-fall-through FIFO storing {last, data} with level count.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_sink_fifo
    import axis_stream_sink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int PTR_W     = ptr_width(DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    output logic                  push_ready,
    input  logic                  pop_en,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_last,
    output logic [LVL_W-1:0]      level
);

    logic [DATA_WIDTH:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_empty    = (r_level == '0);
    // Ready derives from registered occupancy only, never from push_valid.
    assign push_ready = !w_full && !rst;
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop_en && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    assign pop_valid             = !w_empty;
    assign {pop_last, pop_data}  = r_mem[r_rd_ptr];
    assign level                 = r_level;

endmodule

`default_nettype wire

// File: rtl/axis_stream_sink.sv
//==============================================================================
// Module  : axis_stream_sink
// Brief   : AXI-Stream sink: FWFT buffering plus incrementing-sequence checker
//           with packet/error counters.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_stream_sink
    import axis_stream_sink_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axis_stream_sink_if.slave  bus
);

    logic                  w_tready;
    logic                  w_beat;
    logic                  w_mismatch;
    chk_state_t            r_state;
    chk_state_t            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic                  r_seq_err;

    axis_sink_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (ACLK),
        .rst        (ARESET),
        .push_valid (bus.S_AXIS_TVALID),
        .push_data  (bus.S_AXIS_TDATA),
        .push_last  (bus.S_AXIS_TLAST),
        .push_ready (w_tready),
        .pop_en     (bus.rd_en),
        .pop_valid  (bus.rd_valid),
        .pop_data   (bus.rd_data),
        .pop_last   (bus.rd_last),
        .level      (bus.level)
    );

    assign bus.S_AXIS_TREADY = w_tready;
    assign w_beat            = bus.S_AXIS_TVALID && w_tready;

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_beat) w_state_nxt = bus.S_AXIS_TLAST ? ST_IDLE : ST_IN_PKT;
            ST_IN_PKT: if (w_beat && bus.S_AXIS_TLAST) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Only beats after the first of a packet are compared against expectation.
    always_comb begin
        w_mismatch = 1'b0;
        case (r_state)
            ST_IN_PKT: w_mismatch = w_beat && (bus.S_AXIS_TDATA != r_expected);
            default:   w_mismatch = 1'b0;
        endcase
    end

    // Every accepted beat reloads the expectation, which also resyncs after an error.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_expected <= '0;
        end else if (w_beat) begin
            r_expected <= bus.S_AXIS_TDATA + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET || bus.clr) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
            r_seq_err <= 1'b0;
        end else begin
            if (w_beat && bus.S_AXIS_TLAST) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
            end
            if (w_mismatch) begin
                r_err_cnt <= CNT_WIDTH'(sat_inc(64'(r_err_cnt), CNT_WIDTH));
                r_seq_err <= 1'b1;
            end
        end
    end

    assign bus.pkt_cnt = r_pkt_cnt;
    assign bus.err_cnt = r_err_cnt;
    assign bus.seq_err = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_axis_stream_sink.sv
//==============================================================================
// Module  : tb_axis_stream_sink
// Brief   : Self-checking bench for axis_stream_sink (queue model + vectors).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_stream_sink;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_stream_sink_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

    axis_stream_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {last, data}, packet/error bookkeeping.
    logic [DW:0]   mq[$];
    logic [CW-1:0] m_pkt;
    logic [CW-1:0] m_err;
    bit            m_seq;
    bit            m_in_pkt;
    logic [DW-1:0] m_exp;

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          l;
        bit          re;
        bit          c;
        int          lvl;
        int          pkt;
        int          err;
        bit          seq;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_pkt = '0; m_err = '0; m_seq = 0; m_in_pkt = 0; m_exp = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        bus.S_AXIS_TVALID = 1; bus.S_AXIS_TDATA = 32'hDEAD; bus.S_AXIS_TLAST = 0;
        bus.rd_en = 0; bus.clr = 0;
        #1;
        check("tready_in_reset", bus.S_AXIS_TREADY, 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
        check("rst_level",   bus.level, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_pkt",     bus.pkt_cnt, 0);
        check("rst_err",     bus.err_cnt, 0);
        check("rst_seq",     bus.seq_err, 0);
    endtask

    // One clock: drive, check pre-edge outputs, advance model, check registered outputs.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit re, input bit c);
        bit acc, pop, mis;
        bus.S_AXIS_TVALID = v; bus.S_AXIS_TDATA = d; bus.S_AXIS_TLAST = l;
        bus.rd_en = re; bus.clr = c;
        #1;
        check("tready",   bus.S_AXIS_TREADY, 64'(mq.size() != DEPTH));
        check("rd_valid", bus.rd_valid,      64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("rd_data", bus.rd_data, 64'(mq[0][DW-1:0]));
            check("rd_last", bus.rd_last, 64'(mq[0][DW]));
        end
        acc = v && (mq.size() != DEPTH);
        pop = re && (mq.size() != 0);
        mis = acc && m_in_pkt && (d != m_exp);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({l, d});
        if (mis) begin
            m_seq = 1;
            if (m_err != '1) m_err = m_err + 1'b1;
        end
        if (acc) begin
            m_exp    = d + 1;
            m_in_pkt = !l;
            if (l) m_pkt = m_pkt + 1'b1;
        end
        if (c) begin
            m_pkt = '0; m_err = '0; m_seq = 0;
        end
        #1;
        check("level",   bus.level,   64'(mq.size()));
        check("pkt_cnt", bus.pkt_cnt, 64'(m_pkt));
        check("err_cnt", bus.err_cnt, 64'(m_err));
        check("seq_err", bus.seq_err, 64'(m_seq));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] k;
        bit            pred;

        vecs[0] = '{1, 10, 0, 0, 0, 1, 0, 0, 0};
        vecs[1] = '{1, 11, 0, 0, 0, 2, 0, 0, 0};
        vecs[2] = '{1, 13, 0, 0, 0, 3, 0, 1, 1};
        vecs[3] = '{1, 14, 1, 0, 0, 4, 1, 1, 1};
        vecs[4] = '{1, 20, 0, 0, 0, 5, 1, 1, 1};
        vecs[5] = '{1, 22, 1, 0, 1, 6, 0, 0, 0};
        vecs[6] = '{1,  5, 1, 1, 0, 6, 1, 0, 0};
        vecs[7] = '{0,  0, 0, 1, 0, 5, 1, 0, 0};

        // 8-beat packet 1..8, nothing popped
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1, DW'(i), i == 8, 0, 0);
        check("p8_level",   bus.level, 8);
        check("p8_pkt",     bus.pkt_cnt, 1);
        check("p8_seq",     bus.seq_err, 0);
        check("p8_rd_data", bus.rd_data, 1);
        check("p8_rd_last", bus.rd_last, 0);

        // Fill past full, then release one slot
        do_reset();
        k = 1;
        for (int i = 0; i < 20; i++) begin
            pred = (mq.size() != DEPTH);
            cycle(1, k, 0, 0, 0);
            if (pred) k++;
        end
        check("full_tready", bus.S_AXIS_TREADY, 0);
        check("full_level",  bus.level, 16);
        cycle(1, k, 0, 1, 0);
        check("after_pop_tready", bus.S_AXIS_TREADY, 1);
        cycle(1, k, 0, 0, 0);
        k++;
        check("beat17_level", bus.level, 16);

        // Drain, refill to 5, then steady push+pop across wrap
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin cycle(1, k, 0, 0, 0); k++; end
        for (int i = 0; i < 20; i++) begin
            cycle(1, k, 0, 1, 0);
            k++;
            check("steady_level", bus.level, 5);
        end

        // Sequence-error packet and clear-priority vectors
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].re, vecs[i].c);
            check($sformatf("vec%0d_level", i), bus.level,   64'(vecs[i].lvl));
            check($sformatf("vec%0d_pkt", i),   bus.pkt_cnt, 64'(vecs[i].pkt));
            check($sformatf("vec%0d_err", i),   bus.err_cnt, 64'(vecs[i].err));
            check($sformatf("vec%0d_seq", i),   bus.seq_err, 64'(vecs[i].seq));
        end

        // Reset in the middle of a packet
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, DW'(50 + i), 0, 0, 0);
        check("mid_level", bus.level, 3);
        do_reset();
        cycle(1, 200, 1, 0, 0);
        check("post_rst_seq", bus.seq_err, 0);
        check("post_rst_err", bus.err_cnt, 0);
        check("post_rst_pkt", bus.pkt_cnt, 1);

        // Randomized traffic against the model
        do_reset();
        k = $urandom;
        for (int i = 0; i < 600; i++) begin
            bit            v, l, re, c;
            logic [DW-1:0] d;
            v  = ($urandom % 4) != 0;
            d  = (($urandom % 10) == 0) ? DW'($urandom) : k;
            l  = ($urandom % 6) == 0;
            re = (i < 300) ? (($urandom % 3) == 0) : (($urandom % 3) != 0);
            c  = ($urandom % 50) == 0;
            pred = v && (mq.size() != DEPTH);
            cycle(v, d, l, re, c);
            if (pred) k = d + 1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
